rom_load_ctrl: RTL and testbench

- Sits between the HPS ioctl download stream and the game core's ROM/PROM write ports.
- Decodes the linear download address into CPU ROM, graphics ROM and colour PROM regions, and generates registered per-region write strobes.
- Tracks download completeness and an 8-bit additive checksum.
- Holds the game core in reset until a complete, correctly sized image has loaded, plus a post-load settle period.

---
 rtl/rom_load_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_rom_load_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_load_ctrl.sv
`timescale 1ns/1ps
// rom_load_ctrl: steers the HPS ioctl byte stream into the CPU ROM, graphics
// ROM and colour PROM write ports. It checks that the image is complete and
// correctly sized, and keeps the game core in reset until a good image has
// loaded and a short settle period has passed.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  IDLE   | no image present since reset; game held in reset
//  LOAD   | selected download active; writes decoded, counted and summed
//  HOLD   | image complete and correctly sized; settle counter running
//  DONE   | valid image present; game released from reset
//  ERR    | last download was short, long or out of range; game held in reset
module rom_load_ctrl #(
    parameter logic [7:0] ROM_INDEX  = 8'd0,
    parameter int         CPU_SIZE   = 8192,
    parameter int         GFX_SIZE   = 2048,
    parameter int         PROM_SIZE  = 256,
    parameter int         RESET_HOLD = 64
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [13:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        cpu_rom_wr,
    output logic        gfx_wr,
    output logic        prom_wr,
    output logic        game_reset,
    output logic        rom_loaded,
    output logic        load_error,
    output logic [14:0] byte_count,
    output logic [7:0]  checksum
);

    localparam int TOTAL  = CPU_SIZE + GFX_SIZE + PROM_SIZE;
    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    // Region bases are compared on the full address. The subtraction only
    // needs the low 14 bits because every region fits in dn_addr.
    localparam logic [24:0] GFX_BASE_A  = 25'(CPU_SIZE);
    localparam logic [24:0] PROM_BASE_A = 25'(CPU_SIZE + GFX_SIZE);
    localparam logic [24:0] TOTAL_A     = 25'(TOTAL);
    localparam logic [13:0] GFX_BASE_L  = 14'(CPU_SIZE);
    localparam logic [13:0] PROM_BASE_L = 14'(CPU_SIZE + GFX_SIZE);
    localparam logic [14:0] TOTAL_CNT   = 15'(TOTAL);
    localparam logic [14:0] CNT_MAX     = 15'h7FFF;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_HOLD = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t            state_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              overflow_q;
    logic [13:0]       dn_addr_q;
    logic [7:0]        dn_data_q;
    logic              cpu_wr_q;
    logic              gfx_wr_q;
    logic              prom_wr_q;
    logic              game_reset_q;
    logic              rom_loaded_q;
    logic              load_error_q;
    logic [14:0]       byte_count_q;
    logic [7:0]        checksum_q;

    logic              selected;
    logic              in_range;
    logic              is_cpu;
    logic              is_gfx;
    logic              wr_live;
    logic              accept;
    logic              reject;
    logic [13:0]       dn_addr_d;
    logic [14:0]       byte_count_d;
    logic [7:0]        checksum_d;

    // Select the image, qualify the write, and decode its region and offset.
    always_comb begin
        selected  = ioctl_download && (ioctl_index == ROM_INDEX);
        in_range  = ioctl_addr < TOTAL_A;
        is_cpu    = ioctl_addr < GFX_BASE_A;
        is_gfx    = !is_cpu && (ioctl_addr < PROM_BASE_A);
        // A write in the same cycle download falls is not part of the image.
        wr_live   = (state_q == S_LOAD) && ioctl_download && ioctl_wr;
        accept    = wr_live && in_range;
        reject    = wr_live && !in_range;
        dn_addr_d = ioctl_addr[13:0];
        if (!is_cpu) begin
            dn_addr_d = is_gfx ? (ioctl_addr[13:0] - GFX_BASE_L)
                               : (ioctl_addr[13:0] - PROM_BASE_L);
        end
        byte_count_d = (byte_count_q == CNT_MAX) ? byte_count_q
                                                 : byte_count_q + 15'd1;
        checksum_d   = checksum_q + ioctl_dout;
    end

    // Load sequencer with registered strobes, status and settle counter.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hold_cnt_q   <= '0;
            overflow_q   <= 1'b0;
            dn_addr_q    <= '0;
            dn_data_q    <= '0;
            cpu_wr_q     <= 1'b0;
            gfx_wr_q     <= 1'b0;
            prom_wr_q    <= 1'b0;
            game_reset_q <= 1'b1;
            rom_loaded_q <= 1'b0;
            load_error_q <= 1'b0;
            byte_count_q <= '0;
            checksum_q   <= '0;
        end else begin
            cpu_wr_q  <= 1'b0;
            gfx_wr_q  <= 1'b0;
            prom_wr_q <= 1'b0;
            if ((state_q != S_LOAD) && selected) begin
                // A new image always starts from scratch, even if it
                // interrupts a settle period or replaces a good image.
                state_q      <= S_LOAD;
                overflow_q   <= 1'b0;
                byte_count_q <= '0;
                checksum_q   <= '0;
                load_error_q <= 1'b0;
                rom_loaded_q <= 1'b0;
                game_reset_q <= 1'b1;
            end else begin
                case (state_q)
                    S_LOAD: begin
                        if (!ioctl_download) begin
                            if ((byte_count_q == TOTAL_CNT) && !overflow_q) begin
                                state_q    <= S_HOLD;
                                hold_cnt_q <= HOLD_LOAD;
                            end else begin
                                state_q      <= S_ERR;
                                load_error_q <= 1'b1;
                            end
                        end else if (accept) begin
                            dn_addr_q    <= dn_addr_d;
                            dn_data_q    <= ioctl_dout;
                            cpu_wr_q     <= is_cpu;
                            gfx_wr_q     <= is_gfx;
                            prom_wr_q    <= !is_cpu && !is_gfx;
                            byte_count_q <= byte_count_d;
                            checksum_q   <= checksum_d;
                        end else if (reject) begin
                            overflow_q <= 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (hold_cnt_q == '0) begin
                            state_q      <= S_DONE;
                            rom_loaded_q <= 1'b1;
                            game_reset_q <= 1'b0;
                        end else begin
                            hold_cnt_q <= hold_cnt_q - 1'b1;
                        end
                    end
                    S_IDLE, S_DONE, S_ERR: begin
                        state_q <= state_q;
                    end
                    default: begin
                        state_q      <= S_IDLE;
                        game_reset_q <= 1'b1;
                        rom_loaded_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign cpu_rom_wr = cpu_wr_q;
    assign gfx_wr     = gfx_wr_q;
    assign prom_wr    = prom_wr_q;
    assign game_reset = game_reset_q;
    assign rom_loaded = rom_loaded_q;
    assign load_error = load_error_q;
    assign byte_count = byte_count_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
`timescale 1ns/1ps
// Bench for rom_load_ctrl: randomized downloads compared every cycle against a
// transaction-level model, plus literal expectations for the key scenarios.
module tb_rom_load_ctrl;

    localparam int CPU   = 8192;
    localparam int GFX   = 2048;
    localparam int PROM  = 256;
    localparam int TOTAL = CPU + GFX + PROM;
    localparam int HOLD  = 64;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [13:0] dn_addr;
    logic [7:0]  dn_data;
    logic        cpu_rom_wr;
    logic        gfx_wr;
    logic        prom_wr;
    logic        game_reset;
    logic        rom_loaded;
    logic        load_error;
    logic [14:0] byte_count;
    logic [7:0]  checksum;

    always #5 clk_sys = ~clk_sys;

    rom_load_ctrl dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .dn_addr(dn_addr), .dn_data(dn_data),
        .cpu_rom_wr(cpu_rom_wr), .gfx_wr(gfx_wr), .prom_wr(prom_wr),
        .game_reset(game_reset), .rom_loaded(rom_loaded), .load_error(load_error),
        .byte_count(byte_count), .checksum(checksum)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_LOAD, M_HOLD, M_DONE, M_ERR} mphase_t;
    mphase_t m_phase = M_IDLE;
    int  m_cyc = 0;
    int  m_release_at = 0;
    bit  m_over = 0;
    int  m_a;
    int  e_dn_addr = 0, e_dn_data = 0, e_bc = 0, e_cs = 0;
    bit  e_cpu = 0, e_gfx = 0, e_prom = 0, e_grst = 1, e_loaded = 0, e_err = 0;

    always @(posedge clk_sys) begin
        m_cyc++;
        e_cpu = 0; e_gfx = 0; e_prom = 0;
        if (reset) begin
            m_phase = M_IDLE; m_over = 0;
            e_dn_addr = 0; e_dn_data = 0; e_bc = 0; e_cs = 0;
            e_grst = 1; e_loaded = 0; e_err = 0;
        end else if (m_phase != M_LOAD && ioctl_download && ioctl_index == 8'd0) begin
            m_phase = M_LOAD; m_over = 0;
            e_bc = 0; e_cs = 0; e_err = 0; e_loaded = 0; e_grst = 1;
        end else if (m_phase == M_LOAD) begin
            if (!ioctl_download) begin
                if (e_bc == TOTAL && !m_over) begin
                    m_phase = M_HOLD;
                    m_release_at = m_cyc + HOLD;
                end else begin
                    m_phase = M_ERR;
                    e_err = 1;
                end
            end else if (ioctl_wr) begin
                m_a = int'(ioctl_addr);
                if (m_a >= TOTAL) begin
                    m_over = 1;
                end else begin
                    if (m_a < CPU) begin
                        e_cpu = 1; e_dn_addr = m_a;
                    end else if (m_a < CPU + GFX) begin
                        e_gfx = 1; e_dn_addr = m_a - CPU;
                    end else begin
                        e_prom = 1; e_dn_addr = m_a - CPU - GFX;
                    end
                    e_dn_data = int'(ioctl_dout);
                    if (e_bc < 32767) e_bc = e_bc + 1;
                    e_cs = (e_cs + int'(ioctl_dout)) % 256;
                end
            end
        end else if (m_phase == M_HOLD && m_cyc == m_release_at) begin
            m_phase = M_DONE; e_loaded = 1; e_grst = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en = 0;
    int n_cpu = 0, n_gfx = 0, n_prom = 0;
    int first_gfx = -1, first_prom = -1;

    always @(negedge clk_sys) begin
        if (chk_en) begin
            check("dn_addr", 32'(dn_addr), 32'(e_dn_addr));
            check("dn_data", 32'(dn_data), 32'(e_dn_data));
            check("cpu_rom_wr", 32'(cpu_rom_wr), 32'(e_cpu));
            check("gfx_wr", 32'(gfx_wr), 32'(e_gfx));
            check("prom_wr", 32'(prom_wr), 32'(e_prom));
            check("game_reset", 32'(game_reset), 32'(e_grst));
            check("rom_loaded", 32'(rom_loaded), 32'(e_loaded));
            check("load_error", 32'(load_error), 32'(e_err));
            check("byte_count", 32'(byte_count), 32'(e_bc));
            check("checksum", 32'(checksum), 32'(e_cs));
            if (cpu_rom_wr === 1'b1) n_cpu++;
            if (gfx_wr === 1'b1) begin
                n_gfx++;
                if (first_gfx < 0) first_gfx = int'(dn_addr);
            end
            if (prom_wr === 1'b1) begin
                n_prom++;
                if (first_prom < 0) first_prom = int'(dn_addr);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic clear_stats();
        n_cpu = 0; n_gfx = 0; n_prom = 0; first_gfx = -1; first_prom = -1;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index = idx;
        ioctl_download = 1'b1;
        ioctl_wr = 1'b0;
        tick();
    endtask

    task automatic write_bytes(input int n, input bit seq, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(15) == 0) begin
                ioctl_wr = 1'b0;
                tick();
            end
            ioctl_wr = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = seq ? 8'(i) : 8'($urandom_range(255));
            tick();
        end
        ioctl_wr = 1'b0;
    endtask

    task automatic drop(input bit with_wr, input int waddr);
        ioctl_download = 1'b0;
        ioctl_wr = with_wr;
        ioctl_addr = 25'(waddr);
        tick();
        ioctl_wr = 1'b0;
    endtask

    // Counts game_reset-high cycles after the download end is registered.
    task automatic measure_hold(input string name);
        int cnt;
        bit seen;
        cnt = 0;
        seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_sys);
            if (game_reset === 1'b0) begin
                seen = 1;
                break;
            end
            cnt++;
        end
        check({name, "_released"}, 32'(seen), 32'd1);
        check(name, 32'(cnt), 32'(HOLD));
        #1;
    endtask

    // ---------------- scenarios ----------------
    int exp_sum;

    initial begin
        reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0;
        ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
        tick(); tick();
        chk_en = 1;
        check("rst_game_reset", 32'(game_reset), 32'd1);
        check("rst_rom_loaded", 32'(rom_loaded), 32'd0);
        check("rst_byte_count", 32'(byte_count), 32'd0);
        reset = 1'b0;
        tick();

        // Full sequential image
        clear_stats();
        start_dl(8'd0);
        write_bytes(TOTAL, 1, 1);
        drop(0, 0);
        measure_hold("t1_hold_cycles");
        check("t1_cpu_pulses", 32'(n_cpu), 32'(CPU));
        check("t1_gfx_pulses", 32'(n_gfx), 32'(GFX));
        check("t1_prom_pulses", 32'(n_prom), 32'(PROM));
        check("t1_first_gfx_addr", 32'(first_gfx), 32'd0);
        check("t1_first_prom_addr", 32'(first_prom), 32'd0);
        check("t1_byte_count", 32'(byte_count), 32'd10496);
        exp_sum = 0;
        for (int i = 0; i < TOTAL; i++) exp_sum += i % 256;
        check("t1_checksum", 32'(checksum), 32'(exp_sum % 256));
        check("t1_rom_loaded", 32'(rom_loaded), 32'd1);

        // Short download; the write coinciding with the fall must be ignored
        start_dl(8'd0);
        write_bytes(5000, 0, 1);
        drop(1, 5000);
        tick();
        check("t2_load_error", 32'(load_error), 32'd1);
        check("t2_rom_loaded", 32'(rom_loaded), 32'd0);
        check("t2_game_reset", 32'(game_reset), 32'd1);
        check("t2_byte_count", 32'(byte_count), 32'd5000);

        // Full image plus one out-of-range write
        start_dl(8'd0);
        write_bytes(TOTAL, 0, 0);
        tick();
        clear_stats();
        ioctl_wr = 1'b1; ioctl_addr = 25'h2900; ioctl_dout = 8'hA5;
        tick();
        ioctl_wr = 1'b0;
        drop(0, 0);
        tick();
        check("t3_strobes", 32'(n_cpu + n_gfx + n_prom), 32'd0);
        check("t3_load_error", 32'(load_error), 32'd1);
        check("t3_byte_count", 32'(byte_count), 32'(TOTAL));

        // Reach DONE, then a foreign-index download must be invisible
        start_dl(8'd0);
        write_bytes(TOTAL, 0, 0);
        drop(0, 0);
        measure_hold("t4_hold_cycles");
        clear_stats();
        start_dl(8'd1);
        write_bytes(TOTAL, 0, 0);
        drop(0, 0);
        tick();
        check("t4_strobes", 32'(n_cpu + n_gfx + n_prom), 32'd0);
        check("t4_rom_loaded", 32'(rom_loaded), 32'd1);
        check("t4_game_reset", 32'(game_reset), 32'd0);

        // Reset in the middle of a load
        start_dl(8'd0);
        write_bytes(100, 0, 0);
        reset = 1'b1;
        tick();
        check("t5_byte_count", 32'(byte_count), 32'd0);
        check("t5_checksum", 32'(checksum), 32'd0);
        check("t5_game_reset", 32'(game_reset), 32'd1);
        check("t5_dn_addr", 32'(dn_addr), 32'd0);
        reset = 1'b0; ioctl_download = 1'b0;
        tick();
        start_dl(8'd0);
        write_bytes(TOTAL, 0, 0);
        drop(0, 0);
        measure_hold("t5_hold_cycles");
        check("t5_rom_loaded", 32'(rom_loaded), 32'd1);

        // New download ten cycles into the settle period
        start_dl(8'd0);
        write_bytes(TOTAL, 0, 0);
        drop(0, 0);
        repeat (10) tick();
        check("t6_in_hold_reset", 32'(game_reset), 32'd1);
        start_dl(8'd0);
        check("t6_restart_count", 32'(byte_count), 32'd0);
        write_bytes(TOTAL, 0, 0);
        drop(0, 0);
        measure_hold("t6_hold_cycles");
        check("t6_rom_loaded", 32'(rom_loaded), 32'd1);
        check("t6_byte_count", 32'(byte_count), 32'(TOTAL));

        repeat (3) tick();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        tests++;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
